// File: rtl/seq_alu_if.sv
// Handshake and operand/result bundle for seq_alu.
// The master drives the request; the slave (the ALU) returns status and result.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               cin;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               flag;

  modport master (output start, op, a, b, cin, input busy, done, result, flag);
  modport slave  (input start, op, a, b, cin, output busy, done, result, flag);
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: add/sub in one step, radix-4 Booth multiply and restoring
// divide iterating over a shared accumulator, behind a start/busy/done handshake.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  seq_alu_if.slave   bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic                 cin_q, cin_d;
  logic [WIDTH-1:0]     m_q, m_d;       // multiplicand / divisor / operand A
  logic [WIDTH-1:0]     mplr_q, mplr_d; // multiplier / dividend-quotient / operand B
  logic [WIDTH+1:0]     acc_q, acc_d;   // Booth partial sum or division remainder
  logic                 qm1_q, qm1_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 flag_q, flag_d;

  logic [WIDTH+1:0]     m_ext, m_dbl, booth_addend, booth_sum, div_trial;
  logic [WIDTH:0]       add_sum, sub_diff;

  assign m_ext     = {{2{m_q[WIDTH-1]}}, m_q};
  assign m_dbl     = {m_q[WIDTH-1], m_q, 1'b0};
  assign booth_sum = acc_q + booth_addend;
  assign div_trial = {1'b0, acc_q[WIDTH-1:0], mplr_q[WIDTH-1]} - {2'b00, m_q};
  assign add_sum   = {1'b0, m_q} + {1'b0, mplr_q} + {{WIDTH{1'b0}}, cin_q};
  assign sub_diff  = {1'b0, m_q} - {1'b0, mplr_q} - {{WIDTH{1'b0}}, cin_q};

  // Booth recoding of multiplier bits {b[i+1], b[i], b[i-1]}
  always_comb begin
    booth_addend = '0;
    case ({mplr_q[1:0], qm1_q})
      3'b001, 3'b010: booth_addend = m_ext;
      3'b011:         booth_addend = m_dbl;
      3'b100:         booth_addend = -m_dbl;
      3'b101, 3'b110: booth_addend = -m_ext;
      default:        booth_addend = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    cin_d    = cin_q;
    m_d      = m_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    qm1_d    = qm1_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    flag_d   = flag_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          state_d = S_EXEC;
          busy_d  = 1'b1;
          op_d    = bus.op;
          cin_d   = bus.cin;
          acc_d   = '0;
          qm1_d   = 1'b0;
          m_d     = (bus.op == OP_DIV) ? bus.b : bus.a;
          mplr_d  = (bus.op == OP_DIV) ? bus.a : bus.b;
          if (bus.op == OP_MUL)                      cnt_d = CW'(WIDTH / 2);
          else if (bus.op == OP_DIV && bus.b != '0)  cnt_d = CW'(WIDTH);
          else                                       cnt_d = '0;
        end
      end
      S_EXEC: begin
        if (cnt_q != '0) begin
          busy_d = 1'b1;
          cnt_d  = cnt_q - CW'(1);
          if (op_q == OP_MUL) begin
            acc_d  = {{2{booth_sum[WIDTH+1]}}, booth_sum[WIDTH+1:2]};
            mplr_d = {booth_sum[1:0], mplr_q[WIDTH-1:2]};
            qm1_d  = mplr_q[1];
          end else if (!div_trial[WIDTH+1]) begin
            acc_d  = {1'b0, div_trial[WIDTH:0]};
            mplr_d = {mplr_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d  = {1'b0, acc_q[WIDTH-1:0], mplr_q[WIDTH-1]};
            mplr_d = {mplr_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          case (op_q)
            OP_ADD: begin
              result_d = {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
              flag_d   = add_sum[WIDTH];
            end
            OP_SUB: begin
              result_d = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
              flag_d   = sub_diff[WIDTH];
            end
            default: begin
              // Divide by zero: dividend is still untouched in mplr_q
              if (op_q == OP_DIV && m_q == '0) begin
                result_d = {mplr_q, {WIDTH{1'b1}}};
                flag_d   = 1'b1;
              end else begin
                result_d = {acc_q[WIDTH-1:0], mplr_q};
                flag_d   = 1'b0;
              end
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      cin_q    <= 1'b0;
      m_q      <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      qm1_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      cin_q    <= cin_d;
      m_q      <= m_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      qm1_q    <= qm1_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flag   = flag_q;
endmodule
